// File: rtl/ctrl_pkg.sv
// Shared types and constants for the control sequencer.
// Optional feature macro: CTRL_MEM_WAIT_EN (T1 stalls on memory_done).
package ctrl_pkg;

  typedef enum logic [3:0] {
    RST,
    T0,
    T1,
    T2,
    LDI_T3,
    LDI_T4,
    LDI_T5,
    BR_T3,
    BR_T4,
    BR_T5,
    BR_T6,
    HALT
  } state_e;

  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_NOP = 5'b00000;

  localparam int IR_OP_HI = 31;
  localparam int IR_OP_LO = 27;
  localparam int IR_RA_HI = 26;
  localparam int IR_RA_LO = 23;
  localparam int IR_C2_HI = 22;
  localparam int IR_C2_LO = 19;

  typedef struct packed {
    logic pc_out;
    logic inc_pc;
    logic mar_in;
    logic z_in;
    logic zlo_out;
    logic pc_in;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic mem_read;
    logic mem_en;
    logic gra;
    logic grb;
    logic r_in;
    logic r_out;
    logic ba_out;
    logic y_in;
    logic c_out;
    logic con_in;
  } strobes_t;

  function automatic logic [4:0] ir_opcode(input logic [31:0] ir);
    return ir[IR_OP_HI:IR_OP_LO];
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational state-to-strobe decode.
// Only PCin in BR_T6 looks past the state (at con_ff_bit).
module ctrl_decode
  import ctrl_pkg::*;
(
  input  state_e     state,
  input  logic       con_ff_bit,
  output strobes_t   strb,
  output logic [4:0] alu_opcode
);

  // one strobe set per state, everything else low
  always_comb begin
    strb       = '0;
    alu_opcode = ALU_NOP;
    unique case (state)
      T0: begin
        strb.pc_out = 1'b1;
        strb.inc_pc = 1'b1;
        strb.mar_in = 1'b1;
        strb.z_in   = 1'b1;
      end
      T1: begin
        strb.zlo_out  = 1'b1;
        strb.pc_in    = 1'b1;
        strb.mdr_in   = 1'b1;
        strb.mem_read = 1'b1;
        strb.mem_en   = 1'b1;
      end
      T2: begin
        strb.mdr_out = 1'b1;
        strb.ir_in   = 1'b1;
      end
      LDI_T3: begin
        strb.grb    = 1'b1;
        strb.ba_out = 1'b1;
        strb.y_in   = 1'b1;
      end
      LDI_T4: begin
        strb.c_out = 1'b1;
        strb.z_in  = 1'b1;
        alu_opcode = ALU_ADD;
      end
      LDI_T5: begin
        strb.zlo_out = 1'b1;
        strb.gra     = 1'b1;
        strb.r_in    = 1'b1;
      end
      BR_T3: begin
        strb.gra    = 1'b1;
        strb.r_out  = 1'b1;
        strb.con_in = 1'b1;
      end
      BR_T4: begin
        strb.pc_out = 1'b1;
        strb.y_in   = 1'b1;
      end
      BR_T5: begin
        strb.c_out = 1'b1;
        strb.z_in  = 1'b1;
        alu_opcode = ALU_ADD;
      end
      BR_T6: begin
        strb.zlo_out = 1'b1;
        strb.pc_in   = con_ff_bit;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch, ldi, branch, halt sequencing.
// Define CTRL_MEM_WAIT_EN to stall T1 until memory_done.
module control_sequencer
  import ctrl_pkg::*;
(
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        con_ff_bit,
  input  logic        memory_done,
  output logic        PCout,
  output logic        IncPC,
  output logic        MARin,
  output logic        Zin,
  output logic        Zlo_out,
  output logic        PCin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Mem_Read,
  output logic        Mem_enable512x32,
  output logic        Gra,
  output logic        Grb,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Yin,
  output logic        Cout,
  output logic        CONin,
  output logic [4:0]  alu_opcode,
  output logic        run,
  output logic        illegal,
  output logic [15:0] instr_count
);

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic        illegal_q, illegal_d;
  logic [4:0]  opcode;
  strobes_t    strb;

  // ra and C2 are consumed by the datapath, not by sequencing
  logic unused_ir;
  assign unused_ir = ^ir[IR_RA_HI:0];

`ifndef CTRL_MEM_WAIT_EN
  logic unused_mem_done;
  assign unused_mem_done = memory_done;
`endif

  assign opcode = ir_opcode(ir);

  // next state, retire counting and illegal detection
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    illegal_d = 1'b0;
    unique case (state_q)
      RST: state_d = T0;
      T0:  state_d = T1;
`ifdef CTRL_MEM_WAIT_EN
      T1:  if (memory_done) state_d = T2;
`else
      T1:  state_d = T2;
`endif
      T2: begin
        if (opcode == OP_LDI) begin
          state_d = LDI_T3;
        end else if (opcode == OP_BR) begin
          state_d = BR_T3;
        end else if (opcode == OP_HALT) begin
          state_d = HALT;
        end else begin
          state_d   = T0;
          illegal_d = 1'b1;
          count_d   = count_q + 16'd1;
        end
      end
      LDI_T3: state_d = LDI_T4;
      LDI_T4: state_d = LDI_T5;
      LDI_T5: begin
        state_d = T0;
        count_d = count_q + 16'd1;
      end
      BR_T3: state_d = BR_T4;
      BR_T4: state_d = BR_T5;
      BR_T5: state_d = BR_T6;
      BR_T6: begin
        state_d = T0;
        count_d = count_q + 16'd1;
      end
      HALT:    state_d = HALT;
      default: state_d = RST;
    endcase
  end

  // state, counter and illegal pulse registers; clear wins
  always_ff @(posedge Clock) begin
    if (clear) begin
      state_q   <= RST;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  ctrl_decode u_decode (
    .state      (state_q),
    .con_ff_bit (con_ff_bit),
    .strb       (strb),
    .alu_opcode (alu_opcode)
  );

  assign PCout            = strb.pc_out;
  assign IncPC            = strb.inc_pc;
  assign MARin            = strb.mar_in;
  assign Zin              = strb.z_in;
  assign Zlo_out          = strb.zlo_out;
  assign PCin             = strb.pc_in;
  assign MDRin            = strb.mdr_in;
  assign MDRout           = strb.mdr_out;
  assign IRin             = strb.ir_in;
  assign Mem_Read         = strb.mem_read;
  assign Mem_enable512x32 = strb.mem_en;
  assign Gra              = strb.gra;
  assign Grb              = strb.grb;
  assign Rin              = strb.r_in;
  assign Rout             = strb.r_out;
  assign BAout            = strb.ba_out;
  assign Yin              = strb.y_in;
  assign Cout             = strb.c_out;
  assign CONin            = strb.con_in;

  assign run         = (state_q != HALT);
  assign illegal     = illegal_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer.
// Stimulus queues per-cycle expectations; a negedge monitor checks them.
module tb_control_sequencer;

  logic        clk;
  logic        clear;
  logic [31:0] ir;
  logic        con_ff_bit;
  logic        memory_done;
  logic        PCout, IncPC, MARin, Zin, Zlo_out, PCin;
  logic        MDRin, MDRout, IRin, Mem_Read, Mem_enable512x32;
  logic        Gra, Grb, Rin, Rout, BAout, Yin, Cout, CONin;
  logic [4:0]  alu_opcode;
  logic        run;
  logic        illegal;
  logic [15:0] instr_count;

  control_sequencer dut (
    .Clock            (clk),
    .clear            (clear),
    .ir               (ir),
    .con_ff_bit       (con_ff_bit),
    .memory_done      (memory_done),
    .PCout            (PCout),
    .IncPC            (IncPC),
    .MARin            (MARin),
    .Zin              (Zin),
    .Zlo_out          (Zlo_out),
    .PCin             (PCin),
    .MDRin            (MDRin),
    .MDRout           (MDRout),
    .IRin             (IRin),
    .Mem_Read         (Mem_Read),
    .Mem_enable512x32 (Mem_enable512x32),
    .Gra              (Gra),
    .Grb              (Grb),
    .Rin              (Rin),
    .Rout             (Rout),
    .BAout            (BAout),
    .Yin              (Yin),
    .Cout             (Cout),
    .CONin            (CONin),
    .alu_opcode       (alu_opcode),
    .run              (run),
    .illegal          (illegal),
    .instr_count      (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [18:0] P_PCOUT  = 19'(1) << 18;
  localparam logic [18:0] P_INCPC  = 19'(1) << 17;
  localparam logic [18:0] P_MARIN  = 19'(1) << 16;
  localparam logic [18:0] P_ZIN    = 19'(1) << 15;
  localparam logic [18:0] P_ZLO    = 19'(1) << 14;
  localparam logic [18:0] P_PCIN   = 19'(1) << 13;
  localparam logic [18:0] P_MDRIN  = 19'(1) << 12;
  localparam logic [18:0] P_MDROUT = 19'(1) << 11;
  localparam logic [18:0] P_IRIN   = 19'(1) << 10;
  localparam logic [18:0] P_MEMRD  = 19'(1) << 9;
  localparam logic [18:0] P_MEMEN  = 19'(1) << 8;
  localparam logic [18:0] P_GRA    = 19'(1) << 7;
  localparam logic [18:0] P_GRB    = 19'(1) << 6;
  localparam logic [18:0] P_RIN    = 19'(1) << 5;
  localparam logic [18:0] P_ROUT   = 19'(1) << 4;
  localparam logic [18:0] P_BAOUT  = 19'(1) << 3;
  localparam logic [18:0] P_YIN    = 19'(1) << 2;
  localparam logic [18:0] P_COUT   = 19'(1) << 1;
  localparam logic [18:0] P_CONIN  = 19'(1) << 0;

  localparam logic [18:0] V_T0 = P_PCOUT | P_INCPC | P_MARIN | P_ZIN;
  localparam logic [18:0] V_T1 =
    P_ZLO | P_PCIN | P_MDRIN | P_MEMRD | P_MEMEN;
  localparam logic [18:0] V_T2   = P_MDROUT | P_IRIN;
  localparam logic [18:0] V_LDI3 = P_GRB | P_BAOUT | P_YIN;
  localparam logic [18:0] V_LDI4 = P_COUT | P_ZIN;
  localparam logic [18:0] V_LDI5 = P_ZLO | P_GRA | P_RIN;
  localparam logic [18:0] V_BR3  = P_GRA | P_ROUT | P_CONIN;
  localparam logic [18:0] V_BR4  = P_PCOUT | P_YIN;
  localparam logic [18:0] V_BR5  = P_COUT | P_ZIN;

  typedef struct {
    string       nm;
    logic [18:0] s;
    logic [4:0]  alu;
    logic        run;
    logic        ill;
    logic [15:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic        ill_pend = 1'b0;
  int          mem_delay = 0;

  logic [18:0] act_s;
  assign act_s = {PCout, IncPC, MARin, Zin, Zlo_out, PCin, MDRin,
                  MDRout, IRin, Mem_Read, Mem_enable512x32, Gra, Grb,
                  Rin, Rout, BAout, Yin, Cout, CONin};

  // monitor: every cycle with a queued expectation is checked
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      if (act_s !== e.s || alu_opcode !== e.alu || run !== e.run ||
          illegal !== e.ill || instr_count !== e.cnt) begin
        fails++;
        $display("FAIL %s: got s=%h alu=%h run=%b ill=%b cnt=%h, want s=%h alu=%h run=%b ill=%b cnt=%h",
                 e.nm, act_s, alu_opcode, run, illegal, instr_count,
                 e.s, e.alu, e.run, e.ill, e.cnt);
      end
    end
  end

  task automatic push(input string nm, input logic [18:0] s,
                      input logic [4:0] alu, input logic rn);
    exp_t e;
    e.nm  = nm;
    e.s   = s;
    e.alu = alu;
    e.run = rn;
    e.ill = ill_pend;
    e.cnt = exp_cnt;
    ill_pend = 1'b0;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] instr);
    ir = instr;
    push("t0", V_T0, 5'd0, 1'b1);
`ifdef CTRL_MEM_WAIT_EN
    for (int i = 0; i < mem_delay; i++) begin
      memory_done = 1'b0;
      push("t1_wait", V_T1, 5'd0, 1'b1);
    end
    memory_done = 1'b1;
    mem_delay = 0;
`else
    memory_done = 1'b0;
`endif
    push("t1", V_T1, 5'd0, 1'b1);
    push("t2", V_T2, 5'd0, 1'b1);
  endtask

  task automatic do_ldi(input logic [3:0] ra);
    fetch({5'b00001, ra, 4'd0, 19'd0});
    push("ldi_t3", V_LDI3, 5'd0, 1'b1);
    push("ldi_t4", V_LDI4, 5'b00011, 1'b1);
    push("ldi_t5", V_LDI5, 5'd0, 1'b1);
    exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic do_br(input logic [3:0] c2, input logic con);
    con_ff_bit = con;
    fetch({5'b10011, 4'd5, c2, 19'd1});
    push("br_t3", V_BR3, 5'd0, 1'b1);
    push("br_t4", V_BR4, 5'd0, 1'b1);
    push("br_t5", V_BR5, 5'b00011, 1'b1);
    push(con ? "br_t6_taken" : "br_t6_not", con ? (P_ZLO | P_PCIN) : P_ZLO,
         5'd0, 1'b1);
    exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic do_ill();
    fetch({5'b11111, 27'd0});
    exp_cnt  = exp_cnt + 16'd1;
    ill_pend = 1'b1;
  endtask

  initial begin
    clear       = 1'b1;
    ir          = 32'd0;
    con_ff_bit  = 1'b0;
    memory_done = 1'b0;
    @(posedge clk);
    #1;
    clear = 1'b0;
    push("rst", 19'd0, 5'd0, 1'b1);

`ifdef CTRL_MEM_WAIT_EN
    mem_delay = 3;
`endif
    do_ldi(4'd5);
    do_br(4'd1, 1'b1);
    do_br(4'd2, 1'b0);
    do_ill();

    // clear lands mid-branch during BR_T4
    con_ff_bit = 1'b1;
    fetch({5'b10011, 4'd5, 4'd3, 19'd1});
    push("br_t3", V_BR3, 5'd0, 1'b1);
    clear = 1'b1;
    push("br_t4_clr", V_BR4, 5'd0, 1'b1);
    clear    = 1'b0;
    exp_cnt  = 16'd0;
    ill_pend = 1'b0;
    push("rst_mid", 19'd0, 5'd0, 1'b1);

    do_ldi(4'd2);

    // counter wrap: preset to all ones then retire one ldi
    force dut.count_q = 16'hFFFF;
    #1;
    release dut.count_q;
    exp_cnt = 16'hFFFF;
    do_ldi(4'd7);

    do_ill();
    fetch({5'b11011, 27'd0});
    for (int i = 0; i < 20; i++) push("halt", 19'd0, 5'd0, 1'b0);
    clear = 1'b1;
    push("halt_clr", 19'd0, 5'd0, 1'b0);
    clear   = 1'b0;
    exp_cnt = 16'd0;
    push("rst_halt", 19'd0, 5'd0, 1'b1);
    do_ldi(4'd1);
    push("t0_end", V_T0, 5'd0, 1'b1);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

endmodule
